bfm_adder: RTL and testbench

- Registered, pipelined 8-bit adder driven by the top-level wrapper's stimulus counter.
- Samples operands A_s and B_s every clock and presents their sum on res_o after a fixed pipeline latency.
- Has no handshake: every clock edge accepts a new operand pair and retires one result.
- Acts as the minimal compute element used to compare simulator throughput.

---
 rtl/bfm_adder.sv | 48 ++++
 tb/tb_bfm_adder.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/bfm_adder.sv
// Registered, pipelined unsigned adder with an optional saturating clamp.
// One operand pair accepted and one result retired every clock, with no handshake.
module bfm_adder #(
   parameter int unsigned WIDTH       = 8,
   parameter int unsigned PIPE_STAGES = 1,
   parameter int unsigned SATURATE    = 0
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic [WIDTH-1:0] A_s,
   input  logic [WIDTH-1:0] B_s,
   output logic [WIDTH-1:0] res_o
);

   if ((PIPE_STAGES < 1) || (PIPE_STAGES > 4)) begin : g_bad_stages
      $error("bfm_adder: PIPE_STAGES must be in 1..4");
   end

   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] result;
   logic [WIDTH-1:0] stage_q [PIPE_STAGES];

   // Add and wrap/clamp both sit in front of stage 1; later stages only delay.
   always_comb begin
      sum = {1'b0, A_s} + {1'b0, B_s};
      if ((SATURATE != 0) && sum[WIDTH]) begin
         result = '1;
      end else begin
         result = sum[WIDTH-1:0];
      end
   end

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         for (int i = 0; i < PIPE_STAGES; i++) begin
            stage_q[i] <= '0;
         end
      end else begin
         stage_q[0] <= result;
         for (int i = 1; i < PIPE_STAGES; i++) begin
            stage_q[i] <= stage_q[i-1];
         end
      end
   end

   assign res_o = stage_q[PIPE_STAGES-1];

endmodule

// File: tb/tb_bfm_adder.sv
// Bench for bfm_adder: three configurations fed from one operand stream, checked every
// cycle against a queue-of-sums model plus directed literal expectations.
module tb_bfm_adder;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [7:0] a = 8'd5;
   logic [7:0] b = 8'd7;
   logic [7:0] res_wrap;
   logic [7:0] res_sat;
   logic [7:0] res_p3;
   bit         chk_en = 1'b0;
   int         passed = 0;
   int         total = 0;
   int unsigned sums[$];

   always #5 clk = ~clk;

   bfm_adder #(.WIDTH(8), .PIPE_STAGES(1), .SATURATE(0)) u_wrap (
      .clk_i(clk), .reset_i(reset_n), .A_s(a), .B_s(b), .res_o(res_wrap)
   );
   bfm_adder #(.WIDTH(8), .PIPE_STAGES(1), .SATURATE(1)) u_sat (
      .clk_i(clk), .reset_i(reset_n), .A_s(a), .B_s(b), .res_o(res_sat)
   );
   bfm_adder #(.WIDTH(8), .PIPE_STAGES(3), .SATURATE(0)) u_p3 (
      .clk_i(clk), .reset_i(reset_n), .A_s(a), .B_s(b), .res_o(res_p3)
   );

   // Model: full-precision sums of every post-reset sample; reset discards them all.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sums.delete();
      end else begin
         sums.push_back(int'(a) + int'(b));
         if (sums.size() > 8) void'(sums.pop_front());
      end
   end

   function automatic logic [7:0] model_out(int p, bit sat);
      int unsigned s;
      if (sums.size() < p) return 8'd0;
      s = sums[sums.size() - p];
      if (sat && s > 255) return 8'd255;
      return 8'(s % 256);
   endfunction

   task automatic check(string name, logic [7:0] act, logic [7:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("stream_wrap", res_wrap, model_out(1, 1'b0));
         check("stream_sat",  res_sat,  model_out(1, 1'b1));
         check("stream_p3",   res_p3,   model_out(3, 1'b0));
      end
   end

   task automatic drive(logic [7:0] va, logic [7:0] vb);
      @(negedge clk);
      #1;
      a = va;
      b = vb;
   endtask

   task automatic async_reset_check(string name);
      @(posedge clk);
      #2 reset_n = 1'b0;
      #1;
      check({name, "_wrap"}, res_wrap, 8'd0);
      check({name, "_sat"},  res_sat,  8'd0);
      check({name, "_p3"},   res_p3,   8'd0);
   endtask

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] exp_wrap;
      logic [7:0] exp_sat;
   } vec_t;

   vec_t vecs[6] = '{
      '{8'd255, 8'd1,   8'd0,   8'd255},
      '{8'd255, 8'd255, 8'd254, 8'd255},
      '{8'd128, 8'd127, 8'd255, 8'd255},
      '{8'd200, 8'd100, 8'd44,  8'd255},
      '{8'd100, 8'd100, 8'd200, 8'd200},
      '{8'd0,   8'd0,   8'd0,   8'd0}
   };

   logic [7:0] lat_exp[5] = '{8'd0, 8'd0, 8'd2, 8'd4, 8'd6};

   initial begin
      // Reset held with operands applied and the clock running.
      @(negedge clk);
      chk_en = 1'b1;
      repeat (3) @(negedge clk);
      check("hold_reset", res_wrap, 8'd0);

      // Release, see 12, then assert reset mid-cycle.
      #1 reset_n = 1'b1;
      @(negedge clk);
      check("first_sum", res_wrap, 8'd12);
      async_reset_check("async_clear");
      @(negedge clk);
      check("held_clear", res_p3, 8'd0);

      // Steady stream.
      #1;
      reset_n = 1'b1;
      a = 8'd1;
      b = 8'd2;
      repeat (2000) @(negedge clk);
      check("steady_wrap", res_wrap, 8'd3);
      check("steady_p3",   res_p3,   8'd3);

      // Wrap/saturate boundary vectors.
      foreach (vecs[i]) begin
         drive(vecs[i].a, vecs[i].b);
         @(negedge clk);
         check("vec_wrap", res_wrap, vecs[i].exp_wrap);
         check("vec_sat",  res_sat,  vecs[i].exp_sat);
      end

      // Latency through three stages after a clean reset.
      async_reset_check("lat_reset");
      @(negedge clk);
      #1;
      reset_n = 1'b1;
      a = 8'd1;
      b = 8'd1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("latency_p3", res_p3, lat_exp[i]);
         #1;
         a = (i < 2) ? 8'(i + 2) : 8'd0;
         b = a;
      end

      // Alternating stream with a partial-cycle reset pulse in the middle.
      for (int i = 0; i < 24; i++) begin
         drive((i % 2 == 0) ? 8'd10 : 8'd0, (i % 2 == 0) ? 8'd20 : 8'd0);
         if (i == 12) begin
            async_reset_check("flush");
            #1 reset_n = 1'b1;
         end
      end
      repeat (4) @(negedge clk);

      chk_en = 1'b0;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
